// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported RAM between instruction fetch and data
//            memory; data wins by default, a starvation counter forces fetch.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [1:0] c_RAM_ACCESS   = 2'd2;
  localparam logic [1:0] c_RAM_ERROR    = 2'd3;
  localparam logic [1:0] c_CODE_RAM     = 2'd1;
  localparam logic [1:0] c_CODE_TIMEOUT = 2'd2;
  localparam logic [3:0] c_STARVE_MAX   = 4'(STARVE_MAX);
  localparam logic [7:0] c_WAIT_LAST    = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [3:0]  r_starve_cnt;
  logic [7:0]  r_wait_cnt;
  logic        r_ram_ren;
  logic        r_ram_wen;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_store;
  logic [1:0]  r_err_code;

  logic w_in_gnt;
  logic w_access;
  logic w_error;
  logic w_timeout;
  logic w_done;
  logic w_dreq;
  logic w_pick_d;

  assign w_in_gnt  = (r_state != IDLE);
  assign w_access  = w_in_gnt && (ramstate == c_RAM_ACCESS);
  assign w_error   = w_in_gnt && (ramstate == c_RAM_ERROR);
  // A RAM error in the last allowed cycle is reported as an error, not a timeout.
  assign w_timeout = w_in_gnt && !w_access && !w_error && (r_wait_cnt == c_WAIT_LAST);
  assign w_done    = w_access || w_error || w_timeout;
  assign w_dreq    = dREN | dWEN;
  assign w_pick_d  = w_dreq && !(iREN && (r_starve_cnt == c_STARVE_MAX));

  // Completion pulses are suppressed if the requester has dropped its request.
  assign ihit  = !RST && (r_state == GNT_I) && w_access && iREN;
  assign dhit  = !RST && (r_state == GNT_D) && w_access && w_dreq;
  assign iload = ihit ? ramload : 32'd0;
  assign dload = dhit ? ramload : 32'd0;
  assign err   = !RST && (w_error || w_timeout);

  assign ramREN   = r_ram_ren;
  assign ramWEN   = r_ram_wen;
  assign ramaddr  = r_ram_addr;
  assign ramstore = r_ram_store;
  assign err_code = r_err_code;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
      r_wait_cnt   <= 8'd0;
      r_ram_ren    <= 1'b0;
      r_ram_wen    <= 1'b0;
      r_ram_addr   <= 32'd0;
      r_ram_store  <= 32'd0;
      r_err_code   <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= 8'd0;
          if (w_pick_d) begin
            r_state     <= GNT_D;
            r_ram_ren   <= !dWEN;
            r_ram_wen   <= dWEN;
            r_ram_addr  <= daddr;
            r_ram_store <= dstore;
            if (!iREN) begin
              r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != c_STARVE_MAX) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end else if (iREN) begin
            r_state      <= GNT_I;
            r_ram_ren    <= 1'b1;
            r_ram_wen    <= 1'b0;
            r_ram_addr   <= iaddr;
            r_ram_store  <= 32'd0;
            r_starve_cnt <= 4'd0;
          end
        end
        default: begin
          if (w_done) begin
            r_state     <= IDLE;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= 32'd0;
            r_ram_store <= 32'd0;
            if (w_error) begin
              r_err_code <= c_CODE_RAM;
            end else if (w_timeout) begin
              r_err_code <= c_CODE_TIMEOUT;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed stimulus with a cycle-level reference model of the
//            IF/MEM RAM arbiter and hand-computed spot checks.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int          STARVE_MAX = 4;
  localparam int          TIMEOUT    = 64;
  localparam logic [31:0] c_LOAD_KEY = 32'h2108_0044;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dstore = 32'd0;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = 32'd0;
  logic [1:0]  ramstate = 2'd0;
  logic        err;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  // RAM responder knobs: lat = BUSY cycles before ACCESS, rsp_err forces ERROR
  int lat     = 0;
  bit rsp_err = 1'b0;
  int gcnt    = 0;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) begin
    #2;
    if (ramREN || ramWEN) gcnt++;
    else gcnt = 0;
    if (gcnt == 0)      ramstate = 2'd0;
    else if (rsp_err)   ramstate = 2'd3;
    else if (gcnt > lat) ramstate = 2'd2;
    else                ramstate = 2'd1;
    ramload = ramaddr ^ c_LOAD_KEY;
  end

  // Reference model: which side holds the RAM, what it latched, how long it has waited
  bit          m_gnt    = 1'b0;
  bit          m_side_d = 1'b0;
  bit          m_wr     = 1'b0;
  logic [31:0] m_addr   = 32'd0;
  logic [31:0] m_store  = 32'd0;
  int          m_waits  = 0;
  int          m_starve = 0;
  logic [1:0]  m_code   = 2'd0;
  string       m_log    = "";

  always @(negedge CLK) begin
    bit acc, er, to, eih, edh, eer;
    acc = m_gnt && (ramstate == 2'd2);
    er  = m_gnt && (ramstate == 2'd3);
    to  = m_gnt && !acc && !er && (m_waits == TIMEOUT - 1);
    eih = !RST && acc && !m_side_d && iREN;
    edh = !RST && acc && m_side_d && (dREN || dWEN);
    eer = !RST && (er || to);
    chk("m_ramREN",   ramREN,   m_gnt && !m_wr);
    chk("m_ramWEN",   ramWEN,   m_gnt && m_wr);
    chk("m_ramaddr",  ramaddr,  m_gnt ? m_addr : 32'd0);
    chk("m_ramstore", ramstore, m_gnt ? m_store : 32'd0);
    chk("m_ihit",     ihit,     eih);
    chk("m_dhit",     dhit,     edh);
    chk("m_iload",    iload,    eih ? (m_addr ^ c_LOAD_KEY) : 32'd0);
    chk("m_dload",    dload,    edh ? (m_addr ^ c_LOAD_KEY) : 32'd0);
    chk("m_err",      err,      eer);
    chk("m_err_code", err_code, m_code);
    if (RST) begin
      m_gnt = 1'b0; m_wr = 1'b0; m_waits = 0; m_starve = 0; m_code = 2'd0;
    end else if (!m_gnt) begin
      if ((dREN || dWEN) && !(iREN && m_starve == STARVE_MAX)) begin
        m_gnt = 1'b1; m_side_d = 1'b1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
        m_waits = 0;
        m_starve = iREN ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
        m_log = {m_log, "D"};
      end else if (iREN) begin
        m_gnt = 1'b1; m_side_d = 1'b0; m_wr = 1'b0; m_addr = iaddr; m_store = 32'd0;
        m_waits = 0; m_starve = 0;
        m_log = {m_log, "I"};
      end
    end else if (acc || er || to) begin
      m_gnt = 1'b0;
      if (er) m_code = 2'd1;
      else if (to) m_code = 2'd2;
    end else begin
      m_waits++;
    end
  end

  initial begin
    int nw, hitat, ih, badst, gc, errat, dh, base;
    string obs;

    // Reset with both requests held
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h100; RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_ramREN", ramREN, 32'd0);
    chk("rst_pulses", {ihit, dhit, err}, 32'd0);
    chk("rst_code", err_code, 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    step(1); RST = 1'b0;
    @(negedge CLK); chk("rel_idle", ramREN | ramWEN, 32'd0);
    @(negedge CLK); chk("rel_gntd", ramREN, 32'd1);
    chk("rel_addr", ramaddr, 32'h100);
    step(1); iREN = 1'b0; dREN = 1'b0;

    // Single fetch, immediate completion
    iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK); chk("if_idle", ramREN, 32'd0);
    @(negedge CLK);
    chk("if_ren", ramREN, 32'd1);
    chk("if_addr", ramaddr, 32'h40);
    chk("if_hit", ihit, 32'd1);
    chk("if_load", iload, 32'h2108_0004);
    step(1); iREN = 1'b0;
    @(negedge CLK); chk("if_ren_1cyc", ramREN, 32'd0);

    // Write with three wait states
    step(1); lat = 3; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    nw = 0; hitat = 0; ih = 0; badst = 0;
    for (int k = 0; k < 12 && hitat == 0; k++) begin
      @(negedge CLK);
      if (ramWEN) begin
        nw++;
        if (ramstore !== 32'hDEAD_BEEF) badst++;
      end
      if (ihit) ih++;
      if (dhit) hitat = nw;
    end
    step(1); dWEN = 1'b0;
    chk("wr_wen_cycles", nw, 32'd4);
    chk("wr_hit_cycle", hitat, 32'd4);
    chk("wr_no_ihit", ih, 32'd0);
    chk("wr_store_held", badst, 32'd0);
    @(negedge CLK); chk("wr_idle", ramWEN, 32'd0);

    // Read and write together is a write
    step(1); lat = 0; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h90; dstore = 32'h1234_5678;
    @(negedge CLK);
    @(negedge CLK);
    chk("both_wen", ramWEN, 32'd1);
    chk("both_ren", ramREN, 32'd0);
    chk("both_hit", dhit, 32'd1);
    step(1); dREN = 1'b0; dWEN = 1'b0;

    // Starvation: both sides held, every access immediate
    base = m_log.len(); obs = "";
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h300; iaddr = 32'h400;
    for (int k = 0; k < 40 && obs.len() < 10; k++) begin
      @(negedge CLK);
      if (dhit) obs = {obs, "D"};
      if (ihit) obs = {obs, "I"};
    end
    step(1); dREN = 1'b0; iREN = 1'b0;
    chk_s("starve_order_dut", obs, "DDDDIDDDDI");
    chk_s("starve_order_model", m_log.substr(base, base + 9), "DDDDIDDDDI");

    // Timeout with RAM stuck BUSY
    lat = 1000; dREN = 1'b1; daddr = 32'h500;
    gc = 0; errat = 0; dh = 0;
    for (int k = 0; k < 90 && errat == 0; k++) begin
      @(negedge CLK);
      if (ramREN) gc++;
      if (dhit) dh++;
      if (err) errat = gc;
    end
    step(1); dREN = 1'b0;
    chk("to_err_cycle", errat, 32'd64);
    chk("to_no_dhit", dh, 32'd0);
    @(negedge CLK);
    chk("to_code", err_code, 32'd2);
    chk("to_idle", ramREN, 32'd0);

    // RAM error during a fetch grant
    step(1); lat = 0; rsp_err = 1'b1; iREN = 1'b1; iaddr = 32'h600;
    gc = 0; errat = 0; ih = 0;
    for (int k = 0; k < 10 && errat == 0; k++) begin
      @(negedge CLK);
      if (ramREN) gc++;
      if (ihit) ih++;
      if (err) errat = gc;
    end
    step(1); iREN = 1'b0; rsp_err = 1'b0;
    chk("er_err_cycle", errat, 32'd1);
    chk("er_no_ihit", ih, 32'd0);
    @(negedge CLK); chk("er_code", err_code, 32'd1);

    // Data read dropped mid-grant
    step(1); lat = 3; dREN = 1'b1; daddr = 32'h700;
    @(negedge CLK);
    @(negedge CLK); chk("dr_gnt", ramREN, 32'd1);
    step(1); dREN = 1'b0;
    gc = 1; dh = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (dhit) dh++;
      if (!ramREN) break;
      gc++;
    end
    chk("dr_gnt_cycles", gc, 32'd4);
    chk("dr_no_dhit", dh, 32'd0);
    chk("dr_idle", ramREN, 32'd0);
    chk("dr_code_held", err_code, 32'd1);

    // Reset arriving in the cycle the RAM completes
    step(1); lat = 1; dREN = 1'b1; daddr = 32'h800;
    @(negedge CLK);
    @(negedge CLK); chk("rm_gnt", ramREN, 32'd1);
    step(1); RST = 1'b1;
    @(negedge CLK); chk("rm_no_pulse", {dhit, err}, 32'd0);
    step(1); RST = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    chk("rm_idle", ramREN, 32'd0);
    chk("rm_code", err_code, 32'd0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single-ported unified RAM between the pipeline's instruction-fetch (IF) and data-memory (MEM) stages. It grants one requester at a time and holds the latched request stable until the RAM reports completion. It returns per-side hit pulses that the pipeline and hazard logic use as stall-release signals. Data requests win by default; a starvation counter guarantees fetch progress.

## Interface
- STARVE_MAX, 4: consecutive data grants while a fetch is pending before fetch is forced to win (1..15).
- TIMEOUT, 64: BUSY cycles in one grant before the transaction is abandoned (2..255).
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- iREN  in  1  instruction fetch request.
- iaddr  in  32  fetch word address.
- iload  out  32  fetch data; valid only while ihit=1.
- ihit  out  1  one-cycle fetch completion pulse.
- dREN, dWEN  in  1 each  data read / write request; both high is an illegal request, treated as a write.
- daddr, dstore  in  32 each  data address / write data.
- dload  out  32  read data; valid only while dhit=1.
- dhit  out  1  one-cycle data completion pulse.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.
- err  out  1  one-cycle pulse on RAM ERROR or timeout.
- err_code  out  2  registered: 0 none, 1 RAM error, 2 timeout; holds until next err.

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Samples requests and latches addr, store data, write flag and side into registers.
  - Goes to GNT_D if dREN|dWEN and NOT (iREN and starve_cnt==STARVE_MAX).
  - Otherwise goes to GNT_I if iREN.
  - Otherwise stays in IDLE.
- RAM outputs are driven only from the latched registers while in GNT_x. In IDLE, ramREN=ramWEN=0 and ramaddr/ramstore=0.
- GNT_x, ramstate==ACCESS:
  - Pulse the matching hit, but only if that side's request is still asserted this cycle.
  - Pass ramload to iload/dload.
  - Return to IDLE.
- GNT_x, ramstate==ERROR: err=1, err_code=1, no hit, return to IDLE.
- GNT_x, BUSY/FREE: increment wait_cnt. When wait_cnt reaches TIMEOUT-1 and the state is not ACCESS: err=1, err_code=2, no hit, return to IDLE.
- A request dropped mid-grant is not aborted. The arbiter waits for ACCESS/ERROR/timeout, then suppresses the hit.
- starve_cnt (4 bit):
  - +1 on each GNT_D entry while iREN=1.
  - Cleared on any GNT_I entry, or on a GNT_D entry with iREN=0.
  - Saturates at STARVE_MAX.
- wait_cnt (8 bit): cleared on every grant entry.
- iload/dload read 0 when the matching hit is low.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - ramREN, ramWEN, ihit, dhit, err = 0; err_code = 0; ramaddr, ramstore, iload, dload = 0.
- Minimum latency: 2 cycles from request to hit (IDLE at cycle 0, GNT at cycle 1 with ACCESS). Back-to-back throughput is 1 access per 2 cycles.
- Requesters must hold REN/WEN, addr and store data until hit. The arbiter uses the copies latched at IDLE.
- Simultaneous iREN and dREN in IDLE: data wins unless starve_cnt==STARVE_MAX.
- A hit and a new request in the same cycle are not granted that cycle. The request is evaluated in the following IDLE cycle.
- RST asserted mid-grant: the next edge returns to IDLE with strobes low, the in-flight RAM access is dropped, and no hit or err is produced.

## Test plan
- Reset: hold RST 2 cycles with iREN=dREN=1 -> all outputs 0. The first cycle after release is IDLE; GNT_D is entered at the following edge.
- Single fetch: iREN=1, iaddr=0x0000_0040, ramstate=ACCESS in GNT with ramload=0x2108_0004.
  - Expect ramREN=1 and ramaddr=0x40 for 1 cycle.
  - Expect ihit=1 with iload=0x2108_0004 on the same cycle.
- Write with wait states: dWEN=1, daddr=0x80, dstore=0xDEAD_BEEF, ramstate BUSY for 3 cycles then ACCESS.
  - Expect ramWEN=1 and ramstore=0xDEAD_BEEF held 4 cycles.
  - Expect dhit on the 4th GNT cycle; ihit stays 0.
- Starvation: dREN and iREN held continuously, each access completing immediately, STARVE_MAX=4.
  - Expect grant order D,D,D,D,I, with ihit on the 5th grant.
  - Expect starve_cnt to return to 0 after the I grant.
- Timeout: dREN=1, ramstate held BUSY, TIMEOUT=64 -> err pulses at the 64th GNT_D cycle, err_code=2, dhit never asserts, state returns to IDLE.
- Error and dropped request:
  - ramstate=ERROR during GNT_I -> err=1, err_code=1, no ihit.
  - Separate case: dREN dropped before ACCESS -> no dhit, state returns to IDLE.
